// File: rtl/pipelined_compressor_accumulator_if.sv
// Valid/ready stream bundle for the compressor accumulator: beat input side and result output side.
interface pipelined_compressor_accumulator_if #(
   parameter int NUM_ELEMENTS = 9,
   parameter int BIT_LEN      = 16,
   parameter int CNT_W        = 8
);
   logic                in_valid;
   logic                in_ready;
   logic [BIT_LEN-1:0]  in_terms [NUM_ELEMENTS];
   logic                in_last;
   logic                out_valid;
   logic                out_ready;
   logic [BIT_LEN-1:0]  out_sum;
   logic [CNT_W-1:0]    out_beats;

   modport master (
      output in_valid, in_terms, in_last, out_ready,
      input  in_ready, out_valid, out_sum, out_beats
   );

   modport slave (
      input  in_valid, in_terms, in_last, out_ready,
      output in_ready, out_valid, out_sum, out_beats
   );
endinterface

// File: rtl/pipelined_compressor_accumulator.sv
// Pipelined multi-operand adder: 3:2 CSA tree with periodic register slices, final CPA,
// optional per-packet accumulation. One global stall signal freezes the whole pipe.
module pipelined_compressor_accumulator #(
   parameter int NUM_ELEMENTS     = 9,
   parameter int BIT_LEN          = 16,
   parameter int LEVELS_PER_STAGE = 2,
   parameter int ACCUMULATE       = 0,
   parameter int CNT_W            = 8
) (
   input logic                            clk,
   input logic                            rst,
   pipelined_compressor_accumulator_if.slave bus
);

   function automatic int calc_levels(input int n);
      int m;
      int l;
      m = n;
      l = 0;
      while (m > 2) begin
         m = 2 * (m / 3) + m % 3;
         l++;
      end
      return l;
   endfunction

   localparam int L    = calc_levels(NUM_ELEMENTS);
   localparam int P    = (L + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;
   localparam int PA   = (P > 0) ? P : 1;
   // at least two rows so the final adder always has an S and a C operand
   localparam int ROWS = (NUM_ELEMENTS < 2) ? 2 : NUM_ELEMENTS;

   typedef logic [ROWS-1:0][BIT_LEN-1:0] rows_t;

   rows_t               slice_q [PA];
   rows_t               slice_d [PA];
   rows_t               slice_new [PA];
   logic [PA-1:0]       slice_vld_q, slice_vld_d;
   logic [PA-1:0]       slice_last_q, slice_last_d;

   rows_t               fin_rows;
   logic                fin_vld;
   logic                fin_last;
   logic [BIT_LEN-1:0]  beat;

   logic                adv;
   logic                out_valid_q, out_valid_d;
   logic [BIT_LEN-1:0]  out_sum_q, out_sum_d;
   logic [CNT_W-1:0]    out_beats_q, out_beats_d;
   logic [BIT_LEN-1:0]  acc_q, acc_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [CNT_W-1:0]    cnt_inc;

   assign adv = !out_valid_q || bus.out_ready;

   // Whole tree unrolled here; levels that start a new stage read the preceding slice register.
   always_comb begin
      rows_t cur;
      rows_t nxt;
      logic [BIT_LEN-1:0] maj;
      int n;
      cur = '0;
      nxt = '0;
      maj = '0;
      for (int i = 0; i < NUM_ELEMENTS; i++) cur[i] = bus.in_terms[i];
      n = NUM_ELEMENTS;
      for (int k = 0; k < PA; k++) slice_new[k] = '0;
      for (int l = 0; l < L; l++) begin
         if (l > 0 && (l % LEVELS_PER_STAGE) == 0) cur = slice_q[l / LEVELS_PER_STAGE - 1];
         nxt = '0;
         for (int t = 0; t < ROWS / 3; t++) begin
            if (3 * t + 2 < n) begin
               maj = (cur[3*t] & cur[3*t+1]) | (cur[3*t] & cur[3*t+2]) | (cur[3*t+1] & cur[3*t+2]);
               nxt[2*t]   = cur[3*t] ^ cur[3*t+1] ^ cur[3*t+2];
               nxt[2*t+1] = maj << 1;
            end
         end
         for (int j = 0; j < 2; j++) begin
            if (j < n % 3) nxt[2*(n/3)+j] = cur[3*(n/3)+j];
         end
         cur = nxt;
         n   = 2 * (n / 3) + n % 3;
         if (((l + 1) % LEVELS_PER_STAGE) == 0 || (l + 1) == L) slice_new[l / LEVELS_PER_STAGE] = cur;
      end
      fin_rows = (P > 0) ? slice_q[PA-1] : cur;
   end

   always_comb begin
      for (int k = 0; k < PA; k++) begin
         slice_d[k]      = slice_q[k];
         slice_vld_d[k]  = slice_vld_q[k];
         slice_last_d[k] = slice_last_q[k];
         if (adv) begin
            slice_d[k] = slice_new[k];
            if (k == 0) begin
               slice_vld_d[k]  = bus.in_valid;
               slice_last_d[k] = bus.in_last;
            end else begin
               slice_vld_d[k]  = slice_vld_q[k-1];
               slice_last_d[k] = slice_last_q[k-1];
            end
         end
      end
   end

   assign fin_vld  = (P > 0) ? slice_vld_q[PA-1]  : bus.in_valid;
   assign fin_last = (P > 0) ? slice_last_q[PA-1] : bus.in_last;
   assign beat     = fin_rows[0] + fin_rows[1];
   assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

   always_comb begin
      out_valid_d = out_valid_q;
      out_sum_d   = out_sum_q;
      out_beats_d = out_beats_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      if (adv) begin
         if (!fin_vld) begin
            out_valid_d = 1'b0;
         end else if (ACCUMULATE == 0) begin
            out_sum_d   = beat;
            out_beats_d = CNT_W'(1);
            out_valid_d = 1'b1;
         end else if (!fin_last) begin
            acc_d       = acc_q + beat;
            cnt_d       = cnt_inc;
            out_valid_d = 1'b0;
         end else begin
            out_sum_d   = acc_q + beat;
            out_beats_d = cnt_inc;
            out_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < PA; k++) slice_q[k] <= '0;
         slice_vld_q  <= '0;
         slice_last_q <= '0;
         out_valid_q  <= 1'b0;
         out_sum_q    <= '0;
         out_beats_q  <= '0;
         acc_q        <= '0;
         cnt_q        <= '0;
      end else begin
         for (int k = 0; k < PA; k++) slice_q[k] <= slice_d[k];
         slice_vld_q  <= slice_vld_d;
         slice_last_q <= slice_last_d;
         out_valid_q  <= out_valid_d;
         out_sum_q    <= out_sum_d;
         out_beats_q  <= out_beats_d;
         acc_q        <= acc_d;
         cnt_q        <= cnt_d;
      end
   end

   assign bus.in_ready  = adv;
   assign bus.out_valid = out_valid_q;
   assign bus.out_sum   = out_sum_q;
   assign bus.out_beats = out_beats_q;

endmodule

// File: tb/tb_pipelined_compressor_accumulator.sv
// Directed bench: four configurations of the compressor accumulator sharing clk/rst.
module tb_pipelined_compressor_accumulator;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // index 0: per-beat N=9, 1: per-beat N=1, 2: accumulate CNT_W=8, 3: accumulate CNT_W=2
   logic        vld [4];
   logic        lst [4];
   logic        ordy [4];
   logic [15:0] trm [4][9];
   logic        ovld [4];
   logic        irdy [4];
   logic [15:0] osum [4];
   logic [7:0]  obeats [4];

   logic [15:0] qsum [4][$];
   logic [7:0]  qbt [4][$];

   pipelined_compressor_accumulator_if #(.NUM_ELEMENTS(9), .BIT_LEN(16), .CNT_W(8)) if0 ();
   pipelined_compressor_accumulator_if #(.NUM_ELEMENTS(1), .BIT_LEN(16), .CNT_W(8)) if1 ();
   pipelined_compressor_accumulator_if #(.NUM_ELEMENTS(9), .BIT_LEN(16), .CNT_W(8)) if2 ();
   pipelined_compressor_accumulator_if #(.NUM_ELEMENTS(9), .BIT_LEN(16), .CNT_W(2)) if3 ();

   pipelined_compressor_accumulator #(.NUM_ELEMENTS(9), .BIT_LEN(16), .LEVELS_PER_STAGE(2),
      .ACCUMULATE(0), .CNT_W(8)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
   pipelined_compressor_accumulator #(.NUM_ELEMENTS(1), .BIT_LEN(16), .LEVELS_PER_STAGE(2),
      .ACCUMULATE(0), .CNT_W(8)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
   pipelined_compressor_accumulator #(.NUM_ELEMENTS(9), .BIT_LEN(16), .LEVELS_PER_STAGE(2),
      .ACCUMULATE(1), .CNT_W(8)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));
   pipelined_compressor_accumulator #(.NUM_ELEMENTS(9), .BIT_LEN(16), .LEVELS_PER_STAGE(2),
      .ACCUMULATE(1), .CNT_W(2)) dut3 (.clk(clk), .rst(rst), .bus(if3.slave));

   assign if0.in_valid = vld[0];  assign if0.in_last = lst[0];  assign if0.out_ready = ordy[0];
   assign if1.in_valid = vld[1];  assign if1.in_last = lst[1];  assign if1.out_ready = ordy[1];
   assign if2.in_valid = vld[2];  assign if2.in_last = lst[2];  assign if2.out_ready = ordy[2];
   assign if3.in_valid = vld[3];  assign if3.in_last = lst[3];  assign if3.out_ready = ordy[3];
   assign if0.in_terms = trm[0];
   assign if1.in_terms[0] = trm[1][0];
   assign if2.in_terms = trm[2];
   assign if3.in_terms = trm[3];

   assign ovld[0] = if0.out_valid;  assign irdy[0] = if0.in_ready;
   assign ovld[1] = if1.out_valid;  assign irdy[1] = if1.in_ready;
   assign ovld[2] = if2.out_valid;  assign irdy[2] = if2.in_ready;
   assign ovld[3] = if3.out_valid;  assign irdy[3] = if3.in_ready;
   assign osum[0] = if0.out_sum;    assign obeats[0] = if0.out_beats;
   assign osum[1] = if1.out_sum;    assign obeats[1] = if1.out_beats;
   assign osum[2] = if2.out_sum;    assign obeats[2] = if2.out_beats;
   assign osum[3] = if3.out_sum;    assign obeats[3] = 8'(if3.out_beats);

   // results handed over to the consumer (valid and ready both high ahead of the edge)
   always @(negedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (ovld[k] && ordy[k]) begin
            qsum[k].push_back(osum[k]);
            qbt[k].push_back(obeats[k]);
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   // val=0 loads terms 1..N, otherwise every term equals val
   task automatic send_beat(input int k, input int val, input logic last);
      int w;
      @(negedge clk);
      vld[k] = 1'b1;
      lst[k] = last;
      for (int i = 0; i < 9; i++) trm[k][i] = (val == 0) ? 16'(i + 1) : 16'(val);
      #1;
      w = 0;
      while (!irdy[k] && w < 50) begin
         @(negedge clk);
         #1;
         w++;
      end
      if (w >= 50) chk("send_timeout", 0, 1);
      @(posedge clk);
      #1;
      vld[k] = 1'b0;
      lst[k] = 1'b0;
   endtask

   task automatic expect_out(input string tag, input int k, input logic [15:0] s, input logic [7:0] b);
      if (qsum[k].size() == 0) begin
         chk({tag, "_missing"}, 0, 1);
      end else begin
         chk({tag, "_sum"}, qsum[k].pop_front(), s);
         chk({tag, "_beats"}, qbt[k].pop_front(), b);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // single beat with latency measured from the accepting edge (that edge counts as 1)
   task automatic latency_beat(input string tag, input int k, input int val, input int lat_exp,
                               input logic [15:0] sum_exp);
      int lat;
      @(negedge clk);
      vld[k] = 1'b1;
      for (int i = 0; i < 9; i++) trm[k][i] = (val == 0) ? 16'(i + 1) : 16'(val);
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      vld[k] = 1'b0;
      while (!ovld[k] && lat < 20) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      chk({tag, "_latency"}, lat, lat_exp);
      chk({tag, "_sum"}, osum[k], sum_exp);
      chk({tag, "_beats"}, obeats[k], 1);
   endtask

   initial begin
      int sent;
      int got;
      for (int k = 0; k < 4; k++) begin
         vld[k] = 1'b0;
         lst[k] = 1'b0;
         ordy[k] = 1'b1;
         for (int i = 0; i < 9; i++) trm[k][i] = '0;
      end
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      for (int k = 0; k < 4; k++) begin
         chk("rst_out_valid", ovld[k], 0);
         chk("rst_out_sum", osum[k], 0);
         chk("rst_out_beats", obeats[k], 0);
         chk("rst_in_ready", irdy[k], 1);
      end

      latency_beat("seq_1to9", 0, 0, 3, 16'd45);
      latency_beat("all_ffff", 0, 16'hFFFF, 3, 16'hFFF7);
      latency_beat("n1_term7", 1, 7, 1, 16'd7);
      idle(3);

      // back-to-back stream, beat b has every term b+1, consumer stalls 4 cycles mid-stream
      sent = 0;
      got = 0;
      for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
         @(negedge clk);
         ordy[0] = !(cyc >= 6 && cyc < 10);
         if (sent < 8) begin
            vld[0] = 1'b1;
            for (int i = 0; i < 9; i++) trm[0][i] = 16'(sent + 1);
         end else begin
            vld[0] = 1'b0;
         end
         #1;
         if (ovld[0]) begin
            chk("stream_sum", osum[0], 16'(9 * (got + 1)));
            chk("stream_in_ready", irdy[0], ordy[0]);
            if (ordy[0]) got++;
         end
         if (vld[0] && irdy[0]) sent++;
      end
      vld[0] = 1'b0;
      ordy[0] = 1'b1;
      chk("stream_count", got, 8);
      idle(4);
      #1;
      chk("stream_no_extra", ovld[0], 0);

      // accumulate: 3-beat packet of ones, then a single-beat packet 1..9
      qsum[2].delete();
      qbt[2].delete();
      send_beat(2, 1, 1'b0);
      send_beat(2, 1, 1'b0);
      send_beat(2, 1, 1'b1);
      send_beat(2, 0, 1'b1);
      idle(6);
      chk("acc_out_count", qsum[2].size(), 2);
      expect_out("acc_pkt3", 2, 16'd27, 8'd3);
      expect_out("acc_pkt1", 2, 16'd45, 8'd1);

      // reset in the middle of a packet: first beat in acc, second still in the tree
      qsum[2].delete();
      qbt[2].delete();
      send_beat(2, 5, 1'b0);
      send_beat(2, 5, 1'b0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midrst_out_valid", ovld[2], 0);
      chk("midrst_in_ready", irdy[2], 1);
      send_beat(2, 2, 1'b0);
      send_beat(2, 2, 1'b1);
      idle(6);
      chk("midrst_out_count", qsum[2].size(), 1);
      expect_out("midrst_pkt2", 2, 16'd36, 8'd2);

      // 2-bit beat counter saturates at 3 on a 5-beat packet
      qsum[3].delete();
      qbt[3].delete();
      for (int b = 0; b < 5; b++) send_beat(3, 1, (b == 4));
      idle(6);
      chk("sat_out_count", qsum[3].size(), 1);
      expect_out("sat_pkt5", 3, 16'd45, 8'd3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got 0, expected 1");
      $fatal(1, "timeout");
   end
endmodule
